cmp_cascade_seq: RTL and testbench

//   Downstream stage of the 8-bit magnitude comparator.

---
 rtl/cmp_cascade_seq.sv | 105 ++++++++++
 tb/tb_cmp_cascade_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cmp_cascade_seq.sv
// Cascades per-byte magnitude-compare flags (MSB byte first) into one wide unsigned compare result.
// The result is delivered over a valid/ready handshake. A malformed flag beat anywhere in a transaction marks the result as an error.
module cmp_cascade_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_valid,
  input  logic in_alb,
  input  logic in_aeb,
  input  logic in_agb,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_alb,
  output logic out_aeb,
  output logic out_agb,
  output logic out_err,
  output logic busy
);

  localparam int unsigned CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NBYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] count;
  logic          decided;
  logic          dec_lt;
  logic          err;

  logic beat_acc_c;
  logic well_formed_c;
  logic last_beat_c;
  logic done_c;

  assign beat_acc_c    = in_valid & (state == ACCUM);
  assign well_formed_c = (in_alb ^ in_aeb ^ in_agb) & ~(in_alb & in_aeb & in_agb);
  assign last_beat_c   = beat_acc_c & (count == LAST_IDX);
  assign done_c        = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = ACCUM;
      ACCUM:   if (last_beat_c) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Beat accumulation: first well-formed non-equal byte decides; errors stick for the transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      decided <= 1'b0;
      dec_lt  <= 1'b0;
      err     <= 1'b0;
    end else if ((state == IDLE) && start) begin
      count   <= '0;
      decided <= 1'b0;
      dec_lt  <= 1'b0;
      err     <= 1'b0;
    end else if (beat_acc_c) begin
      if (count != FULL_CNT) begin
        count <= count + CW'(1);
      end
      if (!well_formed_c) begin
        err <= 1'b1;
      end else if (!decided && (in_alb | in_agb)) begin
        decided <= 1'b1;
        dec_lt  <= in_alb;
      end
    end
  end

  // Outputs decode only state and result registers
  assign in_ready  = (state == ACCUM);
  assign out_valid = done_c;
  assign busy      = (state != IDLE);
  assign out_err   = done_c & err;
  assign out_alb   = done_c & ~err & decided & dec_lt;
  assign out_agb   = done_c & ~err & decided & ~dec_lt;
  assign out_aeb   = done_c & ~err & ~decided;

endmodule

// File: tb/tb_cmp_cascade_seq.sv
// Bench for cmp_cascade_seq: directed vector table, reset corner cases, and random operand pairs
// checked against an arithmetic wide-compare model.
module tb_cmp_cascade_seq;

  localparam int unsigned NB = 4;
  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_alb, in_aeb, in_agb, out_ready;
  logic in_ready, out_valid, out_alb, out_aeb, out_agb, out_err, busy;

  int checks = 0;
  int errors = 0;

  cmp_cascade_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_alb(in_alb), .in_aeb(in_aeb), .in_agb(in_agb), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_alb(out_alb),
    .out_aeb(out_aeb), .out_agb(out_agb), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] beats;
    int          vmode;
    int          rdelay;
    logic [3:0]  exp;
  } vec_t;

  vec_t tbl[10];
  logic [2:0] bad_codes[5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({in_ready, out_valid, out_alb, out_aeb, out_agb, out_err, busy});
  endfunction

  // Runs one transaction; returns {alb,aeb,agb,err} seen in DONE
  task automatic do_txn(input logic [11:0] beats, input int vmode, input int rdelay,
                        input bit noise, output logic [3:0] res);
    int  idx;
    int  cyc;
    logic v;
    logic rdy;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));
    idx = 0;
    cyc = 0;
    while (idx < int'(NB) && cyc < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = 1'((cyc % 3) == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      {in_alb, in_aeb, in_agb} = beats[11 - 3*idx -: 3];
      if (noise) start = 1'($urandom_range(0, 1));
      rdy = in_ready;
      chk("in_ready_accum", 32'(rdy), 32'(1));
      @(posedge clk); #1;
      cyc++;
      if (v && rdy) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("beats_accepted", 32'(idx), 32'(NB));
    chk("in_ready_done", 32'(in_ready), 32'(0));
    chk("out_valid_done", 32'(out_valid), 32'(1));
    res = {out_alb, out_aeb, out_agb, out_err};
    in_valid = 1'b1;
    repeat (rdelay) begin
      @(posedge clk); #1;
      chk("done_stable", 32'({out_valid, in_ready, out_alb, out_aeb, out_agb, out_err}),
          32'({1'b1, 1'b0, res}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'(0));
    chk("idle_after_hs", all_outs(), 32'(0));
    @(posedge clk); #1;
    chk("start_at_hs_ignored", 32'(busy), 32'(0));
  endtask

  initial begin
    logic [3:0]  res;
    logic [31:0] a, b;
    logic [11:0] beats;
    logic [3:0]  exp;
    logic [7:0]  ab, bb;
    bit          corrupt;

    bad_codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    tbl[0] = '{{EQ, EQ, GT, LT},    0, 0, 4'b0010};
    tbl[1] = '{{EQ, EQ, EQ, EQ},    0, 0, 4'b0100};
    tbl[2] = '{{LT, GT, GT, GT},    0, 0, 4'b1000};
    tbl[3] = '{{EQ, EQ, GT, LT},    1, 5, 4'b0010};
    tbl[4] = '{{EQ, 3'b110, EQ, EQ}, 0, 1, 4'b0001};
    tbl[5] = '{{EQ, EQ, EQ, EQ},    0, 0, 4'b0100};
    tbl[6] = '{{GT, EQ, EQ, EQ},    2, 2, 4'b0010};
    tbl[7] = '{{EQ, EQ, EQ, LT},    0, 0, 4'b1000};
    tbl[8] = '{{EQ, EQ, EQ, 3'b000}, 1, 3, 4'b0001};
    tbl[9] = '{{LT, 3'b111, EQ, EQ}, 0, 0, 4'b0001};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {in_alb, in_aeb, in_agb} = 3'b000;
    #3;
    chk("reset_outputs", all_outs(), 32'(0));
    #20;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_idle", all_outs(), 32'(0));

    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].beats, tbl[i].vmode, tbl[i].rdelay, 1'b0, res);
      chk($sformatf("vec%0d_result", i), 32'(res), 32'(tbl[i].exp));
    end

    // Reset in the middle of a transaction
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    {in_alb, in_aeb, in_agb} = GT;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", all_outs(), 32'(0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_txn({EQ, EQ, EQ, LT}, 0, 0, 1'b0, res);
    chk("after_midreset_result", 32'(res), 32'(4'b1000));

    // Random operand pairs, MSB byte streamed first, some with one malformed beat
    for (int n = 0; n < 40; n++) begin
      a = '0;
      b = '0;
      for (int k = 0; k < int'(NB); k++) begin
        ab = 8'($urandom);
        bb = ($urandom_range(0, 1) == 0) ? ab : 8'($urandom);
        a = {a[23:0], ab};
        b = {b[23:0], bb};
        beats[11 - 3*k -: 3] = (ab < bb) ? LT : (ab == bb) ? EQ : GT;
      end
      corrupt = ($urandom_range(0, 3) == 0);
      if (corrupt) beats[11 - 3*$urandom_range(0, 3) -: 3] = bad_codes[$urandom_range(0, 4)];
      exp = corrupt ? 4'b0001 : (a < b) ? 4'b1000 : (a == b) ? 4'b0100 : 4'b0010;
      do_txn(beats, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1, res);
      chk($sformatf("rand%0d a=%h b=%h", n, a, b), 32'(res), 32'(exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
